// File: rtl/register_bank_if.sv
// Register bank bus: operation select, write mask, data in, two read ports and status.
interface register_bank_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned SELW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [3:0]       FunSel;
    logic [DEPTH-1:0] RegEn;
    logic [WIDTH-1:0] I;
    logic [SELW-1:0]  OutASel;
    logic [SELW-1:0]  OutBSel;
    logic [WIDTH-1:0] OutA;
    logic [WIDTH-1:0] OutB;
    logic             Wrap;
    logic             Carry;

    modport master (
        output FunSel, RegEn, I, OutASel, OutBSel,
        input  OutA, OutB, Wrap, Carry
    );

    modport slave (
        input  FunSel, RegEn, I, OutASel, OutBSel,
        output OutA, OutB, Wrap, Carry
    );
endinterface

// File: rtl/register_bank.sv
// Bank of DEPTH registers sharing one function select, with masked parallel update,
// registered wrap/carry status and two combinational read ports.
module register_bank #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned DEPTH    = 4,
    parameter bit          SATURATE = 1'b0
) (
    input logic            Clock,
    input logic            Reset,
    register_bank_if.slave bus
);
    localparam int unsigned HALF = WIDTH / 2;
    localparam int unsigned SELW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];
    logic             wrap_q;
    logic             wrap_d;
    logic             carry_q;
    logic             carry_d;
    logic             seen;

    // Next value of one register for a given operation code.
    function automatic logic [WIDTH-1:0] op_next(input logic [3:0]       fs,
                                                 input logic [WIDTH-1:0] r,
                                                 input logic [WIDTH-1:0] din);
        logic [HALF-1:0] lo;
        lo      = din[HALF-1:0];
        op_next = r;
        case (fs)
            4'b0000: op_next = (SATURATE && r == '0) ? r : r - WIDTH'(1);
            4'b0001: op_next = (SATURATE && r == '1) ? r : r + WIDTH'(1);
            4'b0010: op_next = din;
            4'b0011: op_next = '0;
            4'b0100: op_next = {{HALF{1'b0}}, lo};
            4'b0101: op_next = {r[WIDTH-1:HALF], lo};
            4'b0110: op_next = {lo, r[HALF-1:0]};
            4'b0111: op_next = {{HALF{lo[HALF-1]}}, lo};
            4'b1000: op_next = {r[WIDTH-2:0], 1'b0};
            4'b1001: op_next = {1'b0, r[WIDTH-1:1]};
            4'b1010: op_next = {r[WIDTH-1], r[WIDTH-1:1]};
            4'b1011: op_next = {r[WIDTH-2:0], r[WIDTH-1]};
            4'b1100: op_next = {r[0], r[WIDTH-1:1]};
            4'b1101: op_next = {r[HALF-1:0], r[WIDTH-1:HALF]};
            4'b1110: op_next = ~r;
            default: op_next = r;
        endcase
    endfunction

    // Each enabled register works from its own old value; carry comes from the lowest enabled one.
    always_comb begin
        regs_d  = regs_q;
        wrap_d  = 1'b0;
        carry_d = 1'b0;
        seen    = 1'b0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            if (bus.RegEn[k]) begin
                regs_d[k] = op_next(bus.FunSel, regs_q[k], bus.I);
                if ((bus.FunSel == 4'b0000 && regs_q[k] == '0) ||
                    (bus.FunSel == 4'b0001 && regs_q[k] == '1)) begin
                    wrap_d = 1'b1;
                end
                if (!seen) begin
                    seen = 1'b1;
                    case (bus.FunSel)
                        4'b1000, 4'b1011:          carry_d = regs_q[k][WIDTH-1];
                        4'b1001, 4'b1010, 4'b1100: carry_d = regs_q[k][0];
                        default:                   carry_d = 1'b0;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            for (int k = 0; k < int'(DEPTH); k++) begin
                regs_q[k] <= '0;
            end
            wrap_q  <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            regs_q  <= regs_d;
            wrap_q  <= wrap_d;
            carry_q <= carry_d;
        end
    end

    // Unmatched addresses (>= DEPTH) fall through to zero.
    always_comb begin
        bus.OutA = '0;
        bus.OutB = '0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            if (bus.OutASel == SELW'(k)) bus.OutA = regs_q[k];
            if (bus.OutBSel == SELW'(k)) bus.OutB = regs_q[k];
        end
    end

    assign bus.Wrap  = wrap_q;
    assign bus.Carry = carry_q;
endmodule

// File: tb/tb_register_bank.sv
// Bench for register_bank: wrapping and saturating instances driven in lockstep against an
// arithmetic reference model, plus directed scenarios with literal expectations.
module tb_register_bank;
    localparam int unsigned WIDTH = 16;
    localparam int unsigned DEPTH = 4;

    logic Clock = 1'b0;
    logic Reset = 1'b0;
    int   total = 0;
    int   bad   = 0;
    bit   chk_on = 1'b0;

    int cur_fs = 15, cur_en = 0, cur_din = 0, cur_as = 0, cur_bs = 0;

    // Model state: index 0 = wrapping instance, 1 = saturating instance.
    int mreg   [2][4];
    int mwrap  [2];
    int mcarry [2];

    register_bank_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus0 ();
    register_bank_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus1 ();

    register_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SATURATE(1'b0)) dut0 (
        .Clock(Clock), .Reset(Reset), .bus(bus0));
    register_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SATURATE(1'b1)) dut1 (
        .Clock(Clock), .Reset(Reset), .bus(bus1));

    always #5 Clock = ~Clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Operation results expressed as plain integer arithmetic on 16-bit values.
    function automatic int next_val(input int fs, input int v, input int din, input bit sat);
        int lo;
        lo = din % 256;
        case (fs)
            0:       return (sat && v == 0) ? 0 : (v + 65535) % 65536;
            1:       return (sat && v == 65535) ? 65535 : (v + 1) % 65536;
            2:       return din;
            3:       return 0;
            4:       return lo;
            5:       return (v / 256) * 256 + lo;
            6:       return lo * 256 + v % 256;
            7:       return (lo >= 128) ? 65280 + lo : lo;
            8:       return (v * 2) % 65536;
            9:       return v / 2;
            10:      return v / 2 + (v / 32768) * 32768;
            11:      return (v * 2) % 65536 + v / 32768;
            12:      return v / 2 + (v % 2) * 32768;
            13:      return (v % 256) * 256 + v / 256;
            14:      return 65535 - v;
            default: return v;
        endcase
    endfunction

    task automatic model_edge();
        int  nv [4];
        int  w, c;
        bit  found;
        for (int s = 0; s < 2; s++) begin
            w = 0; c = 0; found = 1'b0;
            for (int k = 0; k < 4; k++) nv[k] = mreg[s][k];
            if (Reset == 1'b0) begin
                for (int k = 0; k < 4; k++) nv[k] = 0;
            end else begin
                for (int k = 0; k < 4; k++) begin
                    if (((cur_en >> k) & 1) == 1) begin
                        nv[k] = next_val(cur_fs, mreg[s][k], cur_din, s == 1);
                        if ((cur_fs == 0 && mreg[s][k] == 0) || (cur_fs == 1 && mreg[s][k] == 65535)) w = 1;
                        if (!found) begin
                            found = 1'b1;
                            if (cur_fs == 8 || cur_fs == 11) c = mreg[s][k] / 32768;
                            else if (cur_fs == 9 || cur_fs == 10 || cur_fs == 12) c = mreg[s][k] % 2;
                        end
                    end
                end
            end
            for (int k = 0; k < 4; k++) mreg[s][k] = nv[k];
            mwrap[s]  = w;
            mcarry[s] = c;
        end
    endtask

    task automatic apply(input bit rst, input int fs, input int en, input int din,
                         input int as, input int bs);
        @(negedge Clock);
        Reset = rst;
        cur_fs = fs; cur_en = en; cur_din = din; cur_as = as; cur_bs = bs;
        bus0.FunSel = 4'(fs);  bus1.FunSel = 4'(fs);
        bus0.RegEn  = 4'(en);  bus1.RegEn  = 4'(en);
        bus0.I      = 16'(din); bus1.I     = 16'(din);
        bus0.OutASel = 2'(as); bus1.OutASel = 2'(as);
        bus0.OutBSel = 2'(bs); bus1.OutBSel = 2'(bs);
    endtask

    task automatic clock_edge();
        @(posedge Clock);
        model_edge();
        chk_on = 1'b1;
        #1;
    endtask

    task automatic step(input bit rst, input int fs, input int en, input int din,
                        input int as, input int bs);
        apply(rst, fs, en, din, as, bs);
        clock_edge();
    endtask

    task automatic check_reads(input string tag);
        chk({tag, "_outa0"}, 32'(bus0.OutA), 32'(mreg[0][cur_as]));
        chk({tag, "_outb0"}, 32'(bus0.OutB), 32'(mreg[0][cur_bs]));
        chk({tag, "_outa1"}, 32'(bus1.OutA), 32'(mreg[1][cur_as]));
        chk({tag, "_outb1"}, 32'(bus1.OutB), 32'(mreg[1][cur_bs]));
    endtask

    // Compare process: full state after each edge, read ports again once new addresses settle.
    initial begin
        forever begin
            @(posedge Clock);
            #1;
            if (chk_on) begin
                check_reads("post");
                chk("post_wrap0",  32'(bus0.Wrap),  32'(mwrap[0]));
                chk("post_carry0", 32'(bus0.Carry), 32'(mcarry[0]));
                chk("post_wrap1",  32'(bus1.Wrap),  32'(mwrap[1]));
                chk("post_carry1", 32'(bus1.Carry), 32'(mcarry[1]));
            end
            @(negedge Clock);
            #2;
            if (chk_on) check_reads("pre");
        end
    end

    initial begin
        bus0.FunSel = 4'hF; bus1.FunSel = 4'hF;
        bus0.RegEn  = '0;   bus1.RegEn  = '0;
        bus0.I      = '0;   bus1.I      = '0;
        bus0.OutASel = '0;  bus1.OutASel = '0;
        bus0.OutBSel = '0;  bus1.OutBSel = '0;

        // Reset, then every read address returns zero.
        step(1'b0, 2, 15, 16'hFFFF, 0, 0);
        step(1'b0, 2, 15, 16'hFFFF, 0, 0);
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 15, 0, 0, k, 3 - k);
            chk("rst_outa", 32'(bus0.OutA), 32'h0);
            chk("rst_outb", 32'(bus1.OutB), 32'h0);
        end
        chk("rst_wrap",  32'(bus0.Wrap),  32'h0);
        chk("rst_carry", 32'(bus1.Carry), 32'h0);

        // Load and half-word writes.
        step(1'b1, 2, 1, 16'h1234, 0, 0);
        chk("load_r0", 32'(bus0.OutA), 32'h1234);
        step(1'b1, 6, 1, 16'h00AB, 0, 1);
        chk("hi_half_r0", 32'(bus0.OutA), 32'hAB34);
        chk("model_r0", 32'(mreg[0][0]), 32'hAB34);
        step(1'b1, 7, 2, 16'h0080, 1, 1);
        chk("sext_r1", 32'(bus1.OutA), 32'hFF80);

        // Decrement through zero: wrap vs saturate.
        step(1'b1, 3, 4, 0, 2, 2);
        step(1'b1, 0, 4, 0, 2, 2);
        chk("dec_wrap_val",  32'(bus0.OutA), 32'hFFFF);
        chk("dec_wrap_flag", 32'(bus0.Wrap), 32'h1);
        chk("dec_sat_val",   32'(bus1.OutA), 32'h0000);
        chk("dec_sat_flag",  32'(bus1.Wrap), 32'h1);
        chk("model_dec",     32'(mreg[0][2]), 32'hFFFF);
        step(1'b1, 15, 4, 0, 2, 2);
        chk("hold_wrap0", 32'(bus0.Wrap), 32'h0);
        chk("hold_wrap1", 32'(bus1.Wrap), 32'h0);

        // Increment through all-ones.
        step(1'b1, 2, 2, 16'hFFFF, 1, 1);
        step(1'b1, 1, 2, 0, 1, 1);
        chk("inc_wrap_val", 32'(bus0.OutA), 32'h0000);
        chk("inc_sat_val",  32'(bus1.OutA), 32'hFFFF);
        chk("inc_sat_flag", 32'(bus1.Wrap), 32'h1);

        // Shift/rotate chain with carry out.
        step(1'b1, 2, 8, 16'h8001, 3, 3);
        step(1'b1, 11, 8, 0, 3, 3);
        chk("rol_val", 32'(bus0.OutA), 32'h0003);
        chk("rol_c",   32'(bus0.Carry), 32'h1);
        step(1'b1, 10, 8, 0, 3, 3);
        chk("asr_val", 32'(bus0.OutA), 32'h0001);
        chk("asr_c",   32'(bus0.Carry), 32'h1);
        step(1'b1, 9, 8, 0, 3, 3);
        chk("lsr_val", 32'(bus0.OutA), 32'h0000);
        chk("lsr_c",   32'(bus0.Carry), 32'h1);
        step(1'b1, 8, 8, 0, 3, 3);
        chk("shl_val", 32'(bus0.OutA), 32'h0000);
        chk("shl_c",   32'(bus0.Carry), 32'h0);

        // Parallel increment; old value visible before the edge.
        step(1'b1, 2, 1, 16'h0005, 0, 1);
        step(1'b1, 2, 2, 16'h00FF, 0, 1);
        apply(1'b1, 1, 3, 0, 0, 1);
        #2;
        chk("no_wt_r0", 32'(bus0.OutA), 32'h0005);
        clock_edge();
        chk("par_r0", 32'(bus0.OutA), 32'h0006);
        chk("par_r1", 32'(bus0.OutB), 32'h0100);

        // Reset wins over a pending load.
        step(1'b1, 2, 1, 16'h1234, 0, 0);
        step(1'b0, 2, 1, 16'hBEEF, 0, 0);
        chk("midrst_r0",    32'(bus0.OutA),  32'h0000);
        chk("midrst_wrap",  32'(bus0.Wrap),  32'h0);
        chk("midrst_carry", 32'(bus0.Carry), 32'h0);

        // Randomized traffic, biased toward boundary data.
        for (int n = 0; n < 800; n++) begin
            bit rst;
            int din;
            rst = ($urandom_range(0, 29) != 0);
            case ($urandom_range(0, 3))
                0:       din = 0;
                1:       din = 16'hFFFF;
                default: din = int'($urandom_range(0, 65535));
            endcase
            step(rst, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), din,
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        @(negedge Clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
